// File: rtl/serial_add16.sv
// Bit-serial add/subtract around a single add1b full adder, LSB first, start/done handshake.
// Define SERIAL_ADD_OVF_EN to build the two's-complement overflow flag; otherwise ovf is tied to 0.

module add1b (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic r,
   output logic co
);

   assign r  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

module serial_add16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] r,
   output logic             co,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             co_q, co_d;

   logic add_r;
   logic add_co;

   add1b u_add1b (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (c_q),
      .r  (add_r),
      .co (add_co)
   );

`ifdef SERIAL_ADD_OVF_EN
   localparam logic [CW-1:0] MSB_IN_BIT = CW'(WIDTH - 2);

   // Carry into the MSB is captured when bit WIDTH-2 is consumed.
   logic c_msb_q, c_msb_d;
   logic ovf_q, ovf_d;

   always_comb begin
      c_msb_d = c_msb_q;
      ovf_d   = ovf_q;
      if (state_q == RUN) begin
         if (cnt_q == MSB_IN_BIT) begin
            c_msb_d = add_co;
         end
         if (cnt_q == LAST_BIT) begin
            ovf_d = c_msb_q ^ add_co;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         c_msb_q <= c_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned (no latches).
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      cnt_d    = cnt_q;
      c_d      = c_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      r_d      = r_q;
      co_d     = co_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = op ? ~b : b;
               c_d     = op ? 1'b1 : ci;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end

         RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            res_sh_d = {add_r, res_sh_q[WIDTH-1:1]};
            c_d      = add_co;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               r_d     = {add_r, res_sh_q[WIDTH-1:1]};
               co_d    = add_co;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         cnt_q    <= '0;
         c_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         r_q      <= '0;
         co_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         cnt_q    <= cnt_d;
         c_q      <= c_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         r_q      <= r_d;
         co_q     <= co_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign r    = r_q;
   assign co   = co_q;

endmodule

// File: tb/tb_serial_add16.sv
// Directed self-checking bench for serial_add16 (WIDTH = 16) with hand-computed results.
// Overflow expectations follow SERIAL_ADD_OVF_EN when it is defined for the build.

module tb_serial_add16;

   localparam int WIDTH = 16;
`ifdef SERIAL_ADD_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] r;
   logic             co;
   logic             ovf;

   int n_cmp;
   int n_err;

   serial_add16 #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .busy  (busy),
      .done  (done),
      .r     (r),
      .co    (co),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Presents a start pulse, returns just after edge t0.
   task automatic start_op(input logic op_i, input logic [WIDTH-1:0] a_i,
                           input logic [WIDTH-1:0] b_i, input logic ci_i);
      @(negedge clk);
      start = 1'b1;
      op    = op_i;
      a     = a_i;
      b     = b_i;
      ci    = ci_i;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_t0", {31'd0, busy}, 32'd1);
   endtask

   // Counts edges until done, with a bound; busy_cyc includes the t0 cycle.
   task automatic wait_done(input string tag, output int edges, output int busy_cyc);
      edges    = 0;
      busy_cyc = 1;
      while (!done && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
         if (busy) busy_cyc++;
      end
      if (!done) check({tag, "_timeout"}, {31'd0, done}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic op_i, input logic [WIDTH-1:0] a_i,
                         input logic [WIDTH-1:0] b_i, input logic ci_i,
                         input logic [WIDTH-1:0] exp_r, input logic exp_co, input logic exp_ovf);
      int edges;
      int busy_cyc;
      start_op(op_i, a_i, b_i, ci_i);
      wait_done(tag, edges, busy_cyc);
      check({tag, "_latency"}, edges, WIDTH);
      check({tag, "_busy_cycles"}, busy_cyc, WIDTH);
      check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_r"}, {16'd0, r}, {16'd0, exp_r});
      check({tag, "_co"}, {31'd0, co}, {31'd0, exp_co});
      check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_r_hold"}, {16'd0, r}, {16'd0, exp_r});
   endtask

   initial begin
      int edges;
      int busy_cyc;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      start = 1'b0;
      op    = 1'b0;
      a     = '0;
      b     = '0;
      ci    = 1'b0;

      #23;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_r", {16'd0, r}, 32'd0);
      check("rst_co", {31'd0, co}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_1_1",      1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
      run_op("add_ffff_1",   1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add_0_0_ci",   1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
      run_op("add_7fff_1",   1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_ON);
      run_op("sub_5_7",      1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_7_5",      1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
      run_op("sub_7_5_ci",   1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);

      // Second start during RUN must be ignored; r keeps 0x0002 until the new done.
      start_op(1'b0, 16'h1234, 16'h1111, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      a     = 16'hFFFF;
      b     = 16'hFFFF;
      check("ign_r_during_run", {16'd0, r}, 32'h0002);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("ign_busy", {31'd0, busy}, 32'd1);
      check("ign_r_still", {16'd0, r}, 32'h0002);
      wait_done("ign", edges, busy_cyc);
      check("ign_latency", edges, WIDTH - 5);
      check("ign_r", {16'd0, r}, 32'h2345);
      check("ign_co", {31'd0, co}, 32'd0);
      @(posedge clk);
      #1;
      check("ign_done_pulse", {31'd0, done}, 32'd0);
      check("ign_no_requeue", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of bit 8.
      start_op(1'b0, 16'h1234, 16'h1111, 1'b0);
      repeat (8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_r", {16'd0, r}, 32'd0);
      check("arst_co", {31'd0, co}, 32'd0);
      check("arst_ovf", {31'd0, ovf}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_00ff_1",   1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
